// File: rtl/cache_repl_pkg.sv
// cache_repl_pkg: shared types and helpers for the cache set replacement engine.
package cache_repl_pkg;

    typedef enum {POL_LRU, POL_FIFO} repl_policy_e;

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_FILL} repl_state_e;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/repl_victim_select.sv
// repl_victim_select: combinational victim pick from ages, valid, dirty and lock bits.
module repl_victim_select
    import cache_repl_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter bit DIRTY_AWARE   = 1'b1
) (
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] ages_i,
    input  logic [NUM_WAYS-1:0]               valid_i,
    input  logic [NUM_WAYS-1:0]               dirty_i,
    input  logic [NUM_WAYS-1:0]               lock_i,
    output logic [NUM_WAYS-1:0]               way_o,
    output logic                              dirty_o,
    output logic                              none_o
);

    localparam int IW = $clog2(NUM_WAYS);

    logic [COUNTER_WIDTH-1:0] age [NUM_WAYS];
    logic                     free_found, o_found, s_found, use_s;
    logic [IW-1:0]            f_idx, o_idx, s_idx, pick;

    // O is the oldest unlocked way, S the oldest unlocked way other than O
    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) age[i] = ages_i[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        free_found = 1'b0;
        f_idx      = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid_i[i] && !lock_i[i]) begin
                free_found = 1'b1;
                f_idx      = IW'(i);
            end
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (!lock_i[i] && (!o_found || age[i] > age[o_idx])) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        s_found = 1'b0;
        s_idx   = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (!lock_i[i] && o_found && IW'(i) != o_idx && (!s_found || age[i] > age[s_idx])) begin
                s_found = 1'b1;
                s_idx   = IW'(i);
            end
        use_s   = DIRTY_AWARE && dirty_i[o_idx] && s_found && !dirty_i[s_idx];
        pick    = free_found ? f_idx : use_s ? s_idx : o_idx;
        none_o  = !o_found;
        way_o   = none_o ? '0 : (NUM_WAYS'(1) << pick);
        dirty_o = !none_o && valid_i[pick] && dirty_i[pick];
    end

endmodule

// File: rtl/cache_set_replacer.sv
// cache_set_replacer: per-set rank table (LRU or FIFO) with a victim request/ack/fill handshake.
module cache_set_replacer
    import cache_repl_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int POLICY        = 0,
    parameter bit DIRTY_AWARE   = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              access_valid,
    input  logic [NUM_WAYS-1:0]               access_way,
    input  logic                              fill_valid,
    input  logic [NUM_WAYS-1:0]               fill_way,
    input  logic [NUM_WAYS-1:0]               valid_in,
    input  logic [NUM_WAYS-1:0]               dirty_in,
    input  logic [NUM_WAYS-1:0]               lock_in,
    input  logic                              victim_req,
    input  logic                              victim_ack,
    output logic                              victim_valid,
    output logic [NUM_WAYS-1:0]               victim_way,
    output logic                              victim_dirty,
    output logic                              victim_none,
    output logic                              busy,
    output logic [NUM_WAYS*COUNTER_WIDTH-1:0] age_o,
    output logic                              err_onehot
);

    localparam bit LRU = (POLICY == int'(POL_LRU));

    logic [COUNTER_WIDTH-1:0] age_q [NUM_WAYS];
    logic [COUNTER_WIDTH-1:0] age_d [NUM_WAYS];
    repl_state_e              state_q, state_d;
    logic [NUM_WAYS-1:0]      vway_q, vway_d;
    logic                     vdirty_q, vdirty_d, vnone_q, vnone_d, err_q, err_d;
    logic                     acc_ok, fill_ok, ev;
    logic [NUM_WAYS-1:0]      ev_way, sel_way;
    logic [COUNTER_WIDTH-1:0] ev_age;
    logic                     sel_dirty, sel_none;

    repl_victim_select #(
        .NUM_WAYS     (NUM_WAYS),
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .DIRTY_AWARE  (DIRTY_AWARE)
    ) u_sel (
        .ages_i (age_o),
        .valid_i(valid_in),
        .dirty_i(dirty_in),
        .lock_i (lock_in),
        .way_o  (sel_way),
        .dirty_o(sel_dirty),
        .none_o (sel_none)
    );

    assign acc_ok  = access_valid && is_onehot(32'(access_way));
    assign fill_ok = fill_valid && is_onehot(32'(fill_way));
    // a fill in the same cycle always wins over an access, even a malformed one
    assign ev      = fill_ok || (!fill_valid && acc_ok && LRU);
    assign ev_way  = fill_ok ? fill_way : access_way;
    assign err_d   = (access_valid && !acc_ok) || (fill_valid && !fill_ok);

    always_comb begin
        ev_age = '0;
        for (int i = 0; i < NUM_WAYS; i++) if (ev_way[i]) ev_age = age_q[i];
        for (int i = 0; i < NUM_WAYS; i++)
            age_d[i] = !ev ? age_q[i] :
                       ev_way[i] ? '0 :
                       (age_q[i] < ev_age) ? age_q[i] + COUNTER_WIDTH'(1) : age_q[i];
    end

    always_comb begin
        state_d  = state_q;
        vway_d   = vway_q;
        vdirty_d = vdirty_q;
        vnone_d  = vnone_q;
        if (state_q == IDLE && victim_req) begin
            state_d  = OFFER;
            vway_d   = sel_way;
            vdirty_d = sel_dirty;
            vnone_d  = sel_none;
        end else if (state_q == OFFER && victim_ack)
            state_d = vnone_q ? IDLE : WAIT_FILL;
        else if (state_q == WAIT_FILL && fill_valid && fill_way == vway_q)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= COUNTER_WIDTH'(i);
            state_q  <= IDLE;
            vway_q   <= '0;
            vdirty_q <= 1'b0;
            vnone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= age_d[i];
            state_q  <= state_d;
            vway_q   <= vway_d;
            vdirty_q <= vdirty_d;
            vnone_q  <= vnone_d;
            err_q    <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_age
        assign age_o[i*COUNTER_WIDTH +: COUNTER_WIDTH] = age_q[i];
    end

    assign victim_valid = (state_q == OFFER);
    assign victim_way   = victim_valid ? vway_q : '0;
    assign victim_dirty = victim_valid && vdirty_q;
    assign victim_none  = victim_valid && vnone_q;
    assign busy         = (state_q != IDLE);
    assign err_onehot   = err_q;

endmodule

// File: tb/tb_cache_set_replacer.sv
// tb_cache_set_replacer: three configurations (LRU, FIFO, LRU without dirty preference)
// checked every cycle against a recency-list model, plus directed literal checks.
module tb_cache_set_replacer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       access_valid = 1'b0, fill_valid = 1'b0, victim_req = 1'b0, victim_ack = 1'b0;
    logic [3:0] access_way = '0, fill_way = '0, valid_in = '0, dirty_in = '0, lock_in = '0;

    logic        vv [3];
    logic [3:0]  wy [3];
    logic        vd [3];
    logic        vn [3];
    logic        bz [3];
    logic        er [3];
    logic [31:0] ao [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_set_replacer #(.NUM_WAYS(4), .COUNTER_WIDTH(8), .POLICY(0), .DIRTY_AWARE(1'b1)) d0 (
        .clk(clk), .rst(rst), .access_valid(access_valid), .access_way(access_way),
        .fill_valid(fill_valid), .fill_way(fill_way), .valid_in(valid_in), .dirty_in(dirty_in),
        .lock_in(lock_in), .victim_req(victim_req), .victim_ack(victim_ack),
        .victim_valid(vv[0]), .victim_way(wy[0]), .victim_dirty(vd[0]), .victim_none(vn[0]),
        .busy(bz[0]), .age_o(ao[0]), .err_onehot(er[0]));

    cache_set_replacer #(.NUM_WAYS(4), .COUNTER_WIDTH(8), .POLICY(1), .DIRTY_AWARE(1'b1)) d1 (
        .clk(clk), .rst(rst), .access_valid(access_valid), .access_way(access_way),
        .fill_valid(fill_valid), .fill_way(fill_way), .valid_in(valid_in), .dirty_in(dirty_in),
        .lock_in(lock_in), .victim_req(victim_req), .victim_ack(victim_ack),
        .victim_valid(vv[1]), .victim_way(wy[1]), .victim_dirty(vd[1]), .victim_none(vn[1]),
        .busy(bz[1]), .age_o(ao[1]), .err_onehot(er[1]));

    cache_set_replacer #(.NUM_WAYS(4), .COUNTER_WIDTH(8), .POLICY(0), .DIRTY_AWARE(1'b0)) d2 (
        .clk(clk), .rst(rst), .access_valid(access_valid), .access_way(access_way),
        .fill_valid(fill_valid), .fill_way(fill_way), .valid_in(valid_in), .dirty_in(dirty_in),
        .lock_in(lock_in), .victim_req(victim_req), .victim_ack(victim_ack),
        .victim_valid(vv[2]), .victim_way(wy[2]), .victim_dirty(vd[2]), .victim_none(vn[2]),
        .busy(bz[2]), .age_o(ao[2]), .err_onehot(er[2]));

    // Model: ord[k][p] is the way at recency position p (0 = most recent), so age = position.
    int         pol [3] = '{0, 1, 0};
    bit         da  [3] = '{1'b1, 1'b1, 1'b0};
    int         ord [3][4];
    int         m_st [3];
    logic [3:0] m_way [3];
    bit         m_dirty [3];
    bit         m_none [3];
    bit         m_err [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 4; p++) ord[k][p] = p;
            m_st[k] = 0; m_way[k] = '0; m_dirty[k] = 0; m_none[k] = 0; m_err[k] = 0;
        end
    endtask

    function automatic int pos_of(int k, int w);
        for (int p = 0; p < 4; p++) if (ord[k][p] == w) return p;
        return -1;
    endfunction

    task automatic touch(int k, int w);
        int p = pos_of(k, w);
        for (int q = p; q > 0; q--) ord[k][q] = ord[k][q-1];
        ord[k][0] = w;
    endtask

    task automatic pick(input int k, output int way, output bit dirty, output bit none);
        int o = -1, s = -1;
        way = -1;
        for (int i = 0; i < 4; i++) if (way < 0 && !valid_in[i] && !lock_in[i]) way = i;
        if (way < 0) begin
            for (int p = 3; p >= 0; p--)
                if (!lock_in[ord[k][p]]) begin
                    if (o < 0) o = ord[k][p];
                    else if (s < 0) s = ord[k][p];
                end
            way = (da[k] && o >= 0 && s >= 0 && dirty_in[o] && !dirty_in[s]) ? s : o;
        end
        none  = (way < 0);
        dirty = !none && valid_in[way] && dirty_in[way];
    endtask

    task automatic model_step(int k);
        bit fok, aok, d, n;
        int ew, w;
        fok = fill_valid && $onehot(fill_way);
        aok = access_valid && $onehot(access_way);
        ew = -1;
        if (fok) ew = $clog2(fill_way);
        else if (!fill_valid && aok && pol[k] == 0) ew = $clog2(access_way);
        m_err[k] = (access_valid && !aok) || (fill_valid && !fok);
        if (m_st[k] == 0 && victim_req) begin
            pick(k, w, d, n);
            m_way[k] = n ? 4'b0000 : 4'(1 << w);
            m_dirty[k] = d;
            m_none[k] = n;
            m_st[k] = 1;
        end else if (m_st[k] == 1 && victim_ack) m_st[k] = m_none[k] ? 0 : 2;
        else if (m_st[k] == 2 && fill_valid && fill_way == m_way[k]) m_st[k] = 0;
        if (ew >= 0) touch(k, ew);
    endtask

    function automatic logic [31:0] exp_ages(int k);
        logic [31:0] r = '0;
        for (int p = 0; p < 4; p++) r[ord[k][p]*8 +: 8] = 8'(p);
        return r;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_valid", k), 32'(vv[k]), 32'(m_st[k] == 1));
            chk($sformatf("d%0d_way", k), 32'(wy[k]), m_st[k] == 1 ? 32'(m_way[k]) : 32'd0);
            chk($sformatf("d%0d_dirty", k), 32'(vd[k]), 32'(m_st[k] == 1 && m_dirty[k]));
            chk($sformatf("d%0d_none", k), 32'(vn[k]), 32'(m_st[k] == 1 && m_none[k]));
            chk($sformatf("d%0d_busy", k), 32'(bz[k]), 32'(m_st[k] != 0));
            chk($sformatf("d%0d_err", k), 32'(er[k]), 32'(m_err[k]));
            chk($sformatf("d%0d_ages", k), ao[k], exp_ages(k));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (!rst) for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        access_valid = 0; fill_valid = 0; victim_req = 0; victim_ack = 0;
        access_way = '0; fill_way = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        cyc();
        rst = 0;
    endtask

    task automatic access(input logic [3:0] w);
        access_valid = 1; access_way = w;
        cyc();
        access_valid = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_ages", ao[0], 32'h03020100);
        chk("rst_valid", 32'(vv[0]), 32'd0);
        rst = 0;
        // all ways invalid: first offer is way 0, clean
        victim_req = 1; cyc(); victim_req = 0;
        chk("s1_valid", 32'(vv[0]), 32'd1);
        chk("s1_way", 32'(wy[0]), 32'h1);
        chk("s1_dirty", 32'(vd[0]), 32'd0);
        victim_ack = 1; cyc(); victim_ack = 0;
        fill_valid = 1; fill_way = 4'b0001; cyc(); fill_valid = 0;
        chk("s1_busy", 32'(bz[0]), 32'd0);
        // LRU access, offer, fill
        do_reset();
        valid_in = 4'b1111; dirty_in = '0; lock_in = '0;
        access(4'b1000);
        chk("s2_ages_lru", ao[0], 32'h00030201);
        chk("s5_ages_fifo", ao[1], 32'h03020100);
        victim_req = 1; cyc(); victim_req = 0;
        chk("s2_way", 32'(wy[0]), 32'h4);
        chk("s5_way_fifo", 32'(wy[1]), 32'h8);
        victim_ack = 1; cyc(); victim_ack = 0;
        fill_valid = 1; fill_way = 4'b0100; cyc(); fill_valid = 0;
        chk("s2_ages_fill", ao[0], 32'h01000302);
        chk("s2_idle", 32'(bz[0]), 32'd0);
        // dirty oldest vs clean second-oldest
        do_reset();
        access(4'b1000);
        dirty_in = 4'b0100;
        victim_req = 1; cyc(); victim_req = 0;
        chk("s3_da_way", 32'(wy[0]), 32'h2);
        chk("s3_da_dirty", 32'(vd[0]), 32'd0);
        chk("s3_nda_way", 32'(wy[2]), 32'h4);
        chk("s3_nda_dirty", 32'(vd[2]), 32'd1);
        // locks
        do_reset();
        dirty_in = '0;
        access(4'b1000);
        lock_in = 4'b0110;
        victim_req = 1; cyc(); victim_req = 0;
        chk("s4_lock_way", 32'(wy[0]), 32'h1);
        do_reset();
        access(4'b1000);
        lock_in = 4'b1111;
        victim_req = 1; cyc(); victim_req = 0;
        chk("s4_none", 32'(vn[0]), 32'd1);
        chk("s4_none_way", 32'(wy[0]), 32'h0);
        victim_ack = 1; cyc(); victim_ack = 0;
        chk("s4_none_idle", 32'(bz[0]), 32'd0);
        lock_in = '0;
        // FIFO ignores accesses; fill beats a same-cycle access
        do_reset();
        for (int i = 0; i < 5; i++) access(4'b1000);
        chk("s5_fifo_ages", ao[1], 32'h03020100);
        do_reset();
        access_valid = 1; access_way = 4'b0001; fill_valid = 1; fill_way = 4'b0100;
        cyc(); idle_inputs();
        chk("s5_fill_wins", ao[0], 32'h03000201);
        // offer stability, malformed input, reset during offer
        do_reset();
        victim_req = 1; cyc(); victim_req = 0;
        chk("s6_offer", 32'(wy[0]), 32'h8);
        lock_in = 4'b1000; dirty_in = 4'b1111;
        access(4'b0100);
        chk("s6_held_way", 32'(wy[0]), 32'h8);
        chk("s6_ages", ao[0], 32'h03000201);
        access(4'b0011);
        chk("s6_err", 32'(er[0]), 32'd1);
        chk("s6_ages_kept", ao[0], 32'h03000201);
        cyc();
        chk("s6_err_clear", 32'(er[0]), 32'd0);
        #2 rst = 1;
        model_reset();
        #1 chk("s6_async_rst", 32'(vv[0]), 32'd0);
        @(negedge clk);
        #1 rst = 0;
        lock_in = '0; dirty_in = '0;
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            access_valid = ($urandom_range(0, 1) == 1);
            access_way = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            fill_valid = ($urandom_range(0, 3) == 0);
            fill_way = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            valid_in = 4'($urandom) | 4'($urandom);
            dirty_in = 4'($urandom);
            lock_in = 4'($urandom) & 4'($urandom) & 4'($urandom);
            victim_req = ($urandom_range(0, 9) < 3);
            victim_ack = ($urandom_range(0, 9) < 4);
            cyc();
        end
        idle_inputs();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
